// File: rtl/spi_rx_sipo.sv
// SPI mode-0 receive path: synchronises sck/ss_n/mosi, assembles NUM_BITS words, valid/ack out.
// Optional overrun detection is compiled in when SPI_RX_OVERRUN_EN is defined.
module spi_rx_sipo #(
  parameter int unsigned NUM_BITS    = 12,
  parameter bit          SHIFT_MSB   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                sck,
  input  logic                ss_n,
  input  logic                mosi,
  input  logic                data_ack,
  output logic [NUM_BITS-1:0] data_out,
  output logic                data_valid,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  localparam int unsigned CntW = $clog2(NUM_BITS + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                   state_q;
  logic [CntW-1:0]          bit_cnt_q;
  logic [NUM_BITS-1:0]      shift_q;
  logic [SYNC_STAGES-1:0]   sck_sync_q;
  logic [SYNC_STAGES-1:0]   ss_sync_q;
  logic [SYNC_STAGES-1:0]   mosi_sync_q;
  logic                     sck_s_d_q;

  logic                     sck_s;
  logic                     ss_s;
  logic                     mosi_s;
  logic                     sck_rise;
  logic                     word_done;
  logic [NUM_BITS-1:0]      shift_next;

  // ss_n synchronisers reset to 1 so no frame is seen while reset releases.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_s_d_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_s_d_q   <= sck_s;
    end
  end

  always_comb begin
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    ss_s       = ss_sync_q[SYNC_STAGES-1];
    mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    sck_rise   = sck_s & ~sck_s_d_q;
    word_done  = (state_q == StShift) && sck_rise && (bit_cnt_q == CntW'(NUM_BITS - 1));
    shift_next = shift_q;
    if (SHIFT_MSB) begin
      shift_next = {shift_q[NUM_BITS-2:0], mosi_s};
    end else begin
      shift_next = {mosi_s, shift_q[NUM_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef SPI_RX_OVERRUN_EN
      overrun    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (data_valid && data_ack) begin
        data_valid <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          bit_cnt_q <= '0;
          shift_q   <= '0;
          if (!ss_s) begin
            state_q <= StShift;
            busy    <= 1'b1;
          end
        end
        StShift: begin
          if (word_done) begin
            // A completion wins over a simultaneous ack, so valid stays high with new data.
            data_out   <= shift_next;
            data_valid <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
`ifdef SPI_RX_OVERRUN_EN
            if (data_valid && !data_ack) begin
              overrun <= 1'b1;
            end
`endif
          end else if (sck_rise && !ss_s) begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q + CntW'(1);
          end
          if (ss_s) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            if (!word_done && (bit_cnt_q != '0)) begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifndef SPI_RX_OVERRUN_EN
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_sipo.sv
// Self-checking bench for spi_rx_sipo: vector table, hand-written corner sequences, random frames.
module tb_spi_rx_sipo;

  localparam int unsigned NB    = 12;
  localparam bit          SMSB  = 1'b1;
  localparam int unsigned SYNC  = 2;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          sck = 1'b0;
  logic          ss_n = 1'b1;
  logic          mosi = 1'b0;
  logic          data_ack = 1'b0;
  logic [NB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int lat = -1;

  spi_rx_sipo #(
    .NUM_BITS   (NB),
    .SHIFT_MSB  (SMSB),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .sck       (sck),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .data_ack  (data_ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] word;
    int            ack_dly;
    logic [NB-1:0] exp;
  } vec_t;

  vec_t vecs[6];
  logic [NB-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: bit i of the serial stream (sent MSB of w first) lands by position rule.
  function automatic logic [NB-1:0] model_word(input logic [NB-1:0] w);
    logic [NB-1:0] r;
    logic bits[NB];
    r = '0;
    for (int i = 0; i < NB; i++) bits[i] = w[NB-1-i];
    for (int i = 0; i < NB; i++) begin
      if (SMSB) r[NB-1-i] = bits[i];
      else      r[i] = bits[i];
    end
    return r;
  endfunction

  task automatic do_reset();
    n_rst = 1'b0; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0; data_ack = 1'b0;
    #20 n_rst = 1'b1;
    #20;
  endtask

  // Sends nbits of w MSB first; sck period 80 ns. Optionally acks in the completion cycle.
  task automatic send_bits(input logic [NB-1:0] w, input int nbits, input bit ack_last);
    for (int i = 0; i < nbits; i++) begin
      mosi = w[NB-1-i];
      #40 sck = 1'b1;
      lat = -1;
      for (int k = 1; k <= 4; k++) begin
        #10;
        if (lat < 0 && data_valid) lat = k;
        if (ack_last && i == nbits - 1 && k == 2) data_ack = 1'b1;
        if (ack_last && i == nbits - 1 && k == 3) data_ack = 1'b0;
      end
      sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    ss_n = 1'b0;
    #40;
    check("busy_in_frame", busy, 1);
  endtask

  task automatic frame_end(input int exp_err);
    int pulses = 0;
    #40 ss_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #10;
      if (frame_err) pulses++;
    end
    check("frame_err_pulses", pulses, exp_err);
    check("busy_after_frame", busy, 0);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!data_valid && k < 20) begin
      #10;
      k++;
    end
    check(name, data_valid, 1);
  endtask

  task automatic do_ack(input int dly, input logic [NB-1:0] exp);
    for (int k = 0; k < dly; k++) begin
      #10;
      check("hold_valid", data_valid, 1);
      check("hold_data", data_out, exp);
    end
    data_ack = 1'b1;
    #10 data_ack = 1'b0;
    check("valid_cleared", data_valid, 0);
  endtask

  initial begin
    logic [NB-1:0] w;
    logic [NB-1:0] e;
    int nw;

    vecs[0] = '{12'hA5C, 3, 12'hA5C};
    vecs[1] = '{12'h000, 0, 12'h000};
    vecs[2] = '{12'hFFF, 1, 12'hFFF};
    vecs[3] = '{12'h800, 2, 12'h800};
    vecs[4] = '{12'h001, 4, 12'h001};
    vecs[5] = '{12'h555, 0, 12'h555};

    do_reset();
    check("rst_data_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);

    // Single-word frames from the vector table.
    foreach (vecs[i]) begin
      frame_begin();
      send_bits(vecs[i].word, NB, 1'b0);
      check("latency", (lat >= 1 && lat <= int'(SYNC) + 2), 1);
      wait_valid("vec_valid");
      check("vec_data", data_out, vecs[i].exp);
      do_ack(vecs[i].ack_dly, vecs[i].exp);
      frame_end(0);
    end

    // Two words in one frame, each acked.
    frame_begin();
    send_bits(12'h123, NB, 1'b0);
    wait_valid("b2b_valid1");
    check("b2b_data1", data_out, 12'h123);
    do_ack(1, 12'h123);
    send_bits(12'hFED, NB, 1'b0);
    wait_valid("b2b_valid2");
    check("b2b_data2", data_out, 12'hFED);
    do_ack(0, 12'hFED);
    frame_end(0);

    // Partial word aborted after 7 bits, then a clean word.
    frame_begin();
    send_bits(12'hABC, 7, 1'b0);
    frame_end(1);
    check("abort_no_valid", data_valid, 0);
    frame_begin();
    send_bits(12'h0FF, NB, 1'b0);
    wait_valid("after_abort_valid");
    check("after_abort_data", data_out, 12'h0FF);
    do_ack(0, 12'h0FF);
    frame_end(0);

    // Reset mid-frame with an unacked word pending and 5 bits shifted.
    frame_begin();
    send_bits(12'h3C3, NB, 1'b0);
    wait_valid("pre_rst_valid");
    send_bits(12'hFFF, 5, 1'b0);
    n_rst = 1'b0;
    #10;
    check("midrst_data_out", data_out, 0);
    check("midrst_valid", data_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_err", frame_err, 0);
    ss_n = 1'b1;
    #20 n_rst = 1'b1;
    #20;
    frame_begin();
    send_bits(12'h6A9, NB, 1'b0);
    wait_valid("post_rst_valid");
    check("post_rst_data", data_out, 12'h6A9);
    do_ack(0, 12'h6A9);
    frame_end(0);

    // Two words never acked: newest data wins; overrun depends on build option.
    frame_begin();
    send_bits(12'h111, NB, 1'b0);
    wait_valid("ovr_valid1");
    send_bits(12'h222, NB, 1'b0);
    #20;
    check("ovr_data", data_out, 12'h222);
    check("ovr_valid", data_valid, 1);
`ifdef SPI_RX_OVERRUN_EN
    check("ovr_flag", overrun, 1);
`else
    check("ovr_flag", overrun, 0);
`endif
    frame_end(0);
    check("ovr_still_valid", data_valid, 1);

    // Ack coincides with the second completion: no overrun, valid stays with new word.
    do_reset();
    frame_begin();
    send_bits(12'h4B4, NB, 1'b0);
    wait_valid("coinc_valid1");
    send_bits(12'h7E1, NB, 1'b1);
    check("coinc_valid", data_valid, 1);
    check("coinc_data", data_out, 12'h7E1);
    check("coinc_overrun", overrun, 0);
    do_ack(1, 12'h7E1);
    frame_end(0);

    // Random frames of 1-3 words, occasionally ending with a partial word.
    for (int f = 0; f < 10; f++) begin
      frame_begin();
      nw = $urandom_range(1, 3);
      for (int j = 0; j < nw; j++) begin
        w = NB'($urandom_range(0, (1 << NB) - 1));
        exp_q.push_back(model_word(w));
        send_bits(w, NB, 1'b0);
        wait_valid("rnd_valid");
        e = exp_q.pop_front();
        check("rnd_data", data_out, e);
        do_ack($urandom_range(0, 5), e);
      end
      if ($urandom_range(0, 1) == 1) begin
        send_bits(NB'($urandom), $urandom_range(1, NB - 1), 1'b0);
        frame_end(1);
        check("rnd_abort_no_valid", data_valid, 0);
      end else begin
        frame_end(0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
